// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

    localparam logic [1:0] MODE_OFF       = 2'd0;
    localparam logic [1:0] MODE_ON        = 2'd1;
    localparam logic [1:0] MODE_BLINK     = 2'd2;
    localparam logic [1:0] MODE_BLINK_DIM = 2'd3;

    // A zero half-period would never expire; treat it as "toggle every cycle".
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

    // LED level for a channel given its mode, blink phase and PWM gate.
    function automatic logic led_level(input logic [1:0] mode,
                                       input logic       phase,
                                       input logic       dim_on);
        logic lvl;
        case (mode)
            MODE_OFF:       lvl = 1'b0;
            MODE_ON:        lvl = 1'b1;
            MODE_BLINK:     lvl = phase;
            MODE_BLINK_DIM: lvl = phase & dim_on;
            default:        lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/multi_led_pattern_gen_if.sv
// Configuration write port: a request/ready handshake plus an error pulse.
interface multi_led_pattern_gen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned PWM_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [PWM_W-1:0] cfg_duty;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/led_channel.sv
// One LED channel: config registers, half-period timer, blink phase and output bit.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned PWM_W        = 8,
    parameter int unsigned RESET_PERIOD = 8388608
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             def_blink_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [PWM_W-1:0] cfg_duty_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    output logic             led_o
);

    logic [1:0]       mode_q,   mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PWM_W-1:0] duty_q,   duty_d;
    logic [CNT_W-1:0] timer_q,  timer_d;
    logic             phase_q,  phase_d;
    logic             led_q,    led_d;

    // Next state: a load restarts the pattern and overrides any timer expiry.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        timer_d  = timer_q;
        phase_d  = phase_q;
        led_d    = led_level(mode_q, phase_q, (pwm_cnt_i < duty_q));

        if (load_i) begin
            mode_d   = cfg_mode_i;
            period_d = CNT_W'(clamp_period(32'(cfg_period_i)));
            duty_d   = cfg_duty_i;
            timer_d  = '0;
            phase_d  = 1'b1;
        end else if (mode_q == MODE_BLINK || mode_q == MODE_BLINK_DIM) begin
            if (timer_q == period_q - CNT_W'(1)) begin
                timer_d = '0;
                phase_d = ~phase_q;
            end else begin
                timer_d = timer_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; the default selector picks heartbeat or dark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= def_blink_i ? MODE_BLINK : MODE_OFF;
            period_q <= def_blink_i ? CNT_W'(RESET_PERIOD) : CNT_W'(1);
            duty_q   <= '0;
            timer_q  <= '0;
            phase_q  <= 1'b1;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/multi_led_pattern_gen.sv
// NUM_CH independently configured LED drivers sharing one PWM counter.
module multi_led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned PWM_W        = 8,
    parameter int unsigned RESET_PERIOD = 8388608
) (
    input  logic                    pin3_clk_16mhz,
    input  logic                    rst_n,
    multi_led_pattern_gen_if.slave  cfg_if,
    output logic [NUM_CH-1:0]       led_out
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic             ready_q;
    logic             err_q, err_d;
    logic             wr_c;
    logic             bad_ch_c;

    // Write decode, error detection and PWM advance.
    always_comb begin
        wr_c     = cfg_if.cfg_valid & ready_q;
        bad_ch_c = (32'(cfg_if.cfg_ch) >= 32'(NUM_CH));
        err_d    = wr_c & bad_ch_c;
        pwm_d    = pwm_q + PWM_W'(1);
    end

    // Shared registers: PWM counter, ready flag, one-cycle error pulse.
    always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pwm_q   <= pwm_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
        end
    end

    assign cfg_if.cfg_ready = ready_q;
    assign cfg_if.cfg_err   = err_q;

    // One channel per LED; channel 0 comes out of reset as the heartbeat.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        led_channel #(
            .CNT_W        (CNT_W),
            .PWM_W        (PWM_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk_i        (pin3_clk_16mhz),
            .rst_ni       (rst_n),
            .load_i       (wr_c && (cfg_if.cfg_ch == CH_W'(i))),
            .def_blink_i  (i == 0),
            .cfg_mode_i   (cfg_if.cfg_mode),
            .cfg_period_i (cfg_if.cfg_period),
            .cfg_duty_i   (cfg_if.cfg_duty),
            .pwm_cnt_i    (pwm_q),
            .led_o        (led_out[i])
        );
    end

endmodule
